// File: rtl/usb_crc_serial.sv
// Bit-serial USB CRC engine, parametrised for CRC5 (tokens) and CRC16 (data).
// Generate mode passes data through and then appends the inverted remainder
// MSB-first; check mode compares the remainder after the whole received
// stream (CRC included) against the fixed USB residual. All state advances
// only on the bit-time strobe so bit-stuffing stalls are absorbed.
module usb_crc_serial #(
    parameter int               WIDTH    = 5,
    parameter logic [WIDTH-1:0] POLY     = 5'b00101,
    parameter logic [WIDTH-1:0] INIT     = 5'b11111,
    parameter logic [WIDTH-1:0] RESIDUAL = 5'b01100
) (
    input  logic clk,
    input  logic rst_b,
    input  logic bit_en,
    input  logic bit_in,
    input  logic stream_begin,
    input  logic stream_done,
    input  logic check_mode,
    input  logic abort,
    output logic bit_out,
    output logic bit_out_valid,
    output logic sending_crc,
    output logic crc_done,
    output logic check_valid,
    output logic check_ok
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_TOP = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_count;
    logic             r_mode;
    logic             r_crc_done;
    logic             r_check_valid;
    logic             r_check_ok;

    logic             w_fb;
    logic [WIDTH-1:0] w_next_rem;

    // One LFSR step of the remainder with the incoming serial bit.
    always_comb begin
        w_fb       = r_rem[WIDTH-1] ^ bit_in;
        w_next_rem = {r_rem[WIDTH-2:0], 1'b0} ^ (w_fb ? POLY : '0);
    end

    // Serial output mux: data passes straight through while shifting, the
    // inverted remainder is emitted MSB-first while sending.
    always_comb begin
        bit_out       = 1'b0;
        bit_out_valid = 1'b0;
        sending_crc   = 1'b0;
        case (r_state)
            S_SHIFT: begin
                bit_out       = bit_in;
                bit_out_valid = bit_en;
            end
            S_SEND: begin
                bit_out       = ~r_rem[r_count];
                bit_out_valid = bit_en;
                sending_crc   = 1'b1;
            end
            default: begin
                bit_out       = 1'b0;
                bit_out_valid = 1'b0;
            end
        endcase
    end

    // Main sequencer: abort wins over everything, pulses default low each cycle.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state       <= S_IDLE;
            r_rem         <= INIT;
            r_count       <= CNT_TOP;
            r_mode        <= 1'b0;
            r_crc_done    <= 1'b0;
            r_check_valid <= 1'b0;
            r_check_ok    <= 1'b0;
        end else begin
            r_crc_done    <= 1'b0;
            r_check_valid <= 1'b0;
            if (abort) begin
                r_state <= S_IDLE;
                r_rem   <= INIT;
                r_count <= CNT_TOP;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (stream_begin) begin
                            r_rem   <= INIT;
                            r_mode  <= check_mode;
                            r_state <= S_SHIFT;
                        end
                    end
                    S_SHIFT: begin
                        if (bit_en) begin
                            r_rem <= w_next_rem;
                            if (stream_done) begin
                                if (r_mode) begin
                                    r_check_valid <= 1'b1;
                                    r_check_ok    <= (w_next_rem == RESIDUAL);
                                    r_state       <= S_IDLE;
                                end else begin
                                    r_count <= CNT_TOP;
                                    r_state <= S_SEND;
                                end
                            end
                        end
                    end
                    S_SEND: begin
                        if (bit_en) begin
                            if (r_count == '0) begin
                                r_crc_done <= 1'b1;
                                r_count    <= CNT_TOP;
                                r_state    <= S_IDLE;
                            end else begin
                                r_count <= r_count - 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign crc_done    = r_crc_done;
    assign check_valid = r_check_valid;
    assign check_ok    = r_check_ok;

endmodule
